// File: rtl/i2c_master_burst.sv
// Multi-byte I2C master: addressed read/write bursts with open-drain pad
// controls and SCL clock-stretch support.
module i2c_master_burst #(
    parameter int CLK_DIV = 4,
    parameter int LEN_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [6:0]       addr,
    input  logic             rw,
    input  logic [LEN_W-1:0] len,
    input  logic [7:0]       tx_data,
    output logic             tx_ready,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    output logic             busy,
    output logic             done,
    output logic             ack_error,
    input  logic             scl_i,
    input  logic             sda_i,
    output logic             scl_oe,
    output logic             sda_oe
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_START,
        S_ADDR,
        S_ADDR_ACK,
        S_WR_BYTE,
        S_WR_ACK,
        S_RD_BYTE,
        S_RD_ACK,
        S_STOP
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       qtr_q, qtr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             rw_q, rw_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic             ack_q, ack_d;
    logic             scl_oe_q, scl_oe_d;
    logic             sda_oe_q, sda_oe_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             tx_ready_q, tx_ready_d;
    logic             rx_valid_q, rx_valid_d;
    logic             ack_error_q, ack_error_d;
    logic [7:0]       rx_data_q, rx_data_d;

    logic hold;
    logic q_end;
    logic smp;
    logic bit_end;

    // q2 only advances once the slave has let SCL go high
    assign hold    = (qtr_q == 2'd2) && !scl_i;
    assign q_end   = (cnt_q == CNT_MAX) && !hold;
    assign smp     = q_end && (qtr_q == 2'd2);
    assign bit_end = q_end && (qtr_q == 2'd3);

    always_comb begin
        state_d     = state_q;
        qtr_d       = qtr_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        rw_d        = rw_q;
        rem_d       = rem_q;
        ack_d       = ack_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        tx_ready_d  = 1'b0;
        rx_valid_d  = 1'b0;
        ack_error_d = ack_error_q;
        rx_data_d   = rx_data_q;

        if (state_q != S_IDLE) begin
            if (q_end) begin
                cnt_d = '0;
                qtr_d = qtr_q + 2'd1;
            end else if (!hold) begin
                cnt_d = cnt_q + CW'(1);
            end
        end
        if (smp) begin
            ack_d = sda_i;
        end

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_START;
                    shift_d     = {addr, rw};
                    rw_d        = rw;
                    rem_d       = len;
                    ack_error_d = 1'b0;
                    busy_d      = 1'b1;
                    cnt_d       = '0;
                    qtr_d       = 2'd0;
                    bit_d       = 3'd7;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                if (bit_end) begin
                    if (bit_q == 3'd0) begin
                        state_d = S_ADDR_ACK;
                    end else begin
                        shift_d = shift_q << 1;
                        bit_d   = bit_q - 3'd1;
                    end
                end
            end
            S_ADDR_ACK: begin
                if (bit_end) begin
                    bit_d = 3'd7;
                    if (ack_q) begin
                        ack_error_d = 1'b1;
                        state_d     = S_STOP;
                    end else if (rem_q == '0) begin
                        state_d = S_STOP;
                    end else if (rw_q) begin
                        state_d = S_RD_BYTE;
                    end else begin
                        state_d    = S_WR_BYTE;
                        shift_d    = tx_data;
                        tx_ready_d = 1'b1;
                    end
                end
            end
            S_WR_BYTE: begin
                if (bit_end) begin
                    if (bit_q == 3'd0) begin
                        state_d = S_WR_ACK;
                    end else begin
                        shift_d = shift_q << 1;
                        bit_d   = bit_q - 3'd1;
                    end
                end
            end
            S_WR_ACK: begin
                if (bit_end) begin
                    if (ack_q) begin
                        ack_error_d = 1'b1;
                        state_d     = S_STOP;
                    end else if (rem_q == LEN_W'(1)) begin
                        state_d = S_STOP;
                    end else begin
                        rem_d      = rem_q - LEN_W'(1);
                        state_d    = S_WR_BYTE;
                        shift_d    = tx_data;
                        tx_ready_d = 1'b1;
                        bit_d      = 3'd7;
                    end
                end
            end
            S_RD_BYTE: begin
                if (smp) begin
                    shift_d = {shift_q[6:0], sda_i};
                    if (bit_q == 3'd0) begin
                        rx_data_d  = {shift_q[6:0], sda_i};
                        rx_valid_d = 1'b1;
                    end
                end
                if (bit_end) begin
                    if (bit_q == 3'd0) begin
                        state_d = S_RD_ACK;
                    end else begin
                        bit_d = bit_q - 3'd1;
                    end
                end
            end
            S_RD_ACK: begin
                if (bit_end) begin
                    if (rem_q == LEN_W'(1)) begin
                        state_d = S_STOP;
                    end else begin
                        rem_d   = rem_q - LEN_W'(1);
                        state_d = S_RD_BYTE;
                        bit_d   = 3'd7;
                    end
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // Pad levels follow the upcoming state so SDA moves with SCL's fall
        scl_oe_d = (state_d != S_IDLE) && (state_d != S_START) && !qtr_d[1];
        case (state_d)
            S_START:             sda_oe_d = qtr_d[1];
            S_ADDR, S_WR_BYTE:   sda_oe_d = !shift_d[7];
            S_RD_ACK:            sda_oe_d = (rem_d != LEN_W'(1));
            S_STOP:              sda_oe_d = (qtr_d != 2'd3);
            default:             sda_oe_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            qtr_q       <= 2'd0;
            cnt_q       <= '0;
            bit_q       <= 3'd7;
            shift_q     <= 8'h00;
            rw_q        <= 1'b0;
            rem_q       <= '0;
            ack_q       <= 1'b0;
            scl_oe_q    <= 1'b0;
            sda_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            tx_ready_q  <= 1'b0;
            rx_valid_q  <= 1'b0;
            ack_error_q <= 1'b0;
            rx_data_q   <= 8'h00;
        end else begin
            state_q     <= state_d;
            qtr_q       <= qtr_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            rw_q        <= rw_d;
            rem_q       <= rem_d;
            ack_q       <= ack_d;
            scl_oe_q    <= scl_oe_d;
            sda_oe_q    <= sda_oe_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            tx_ready_q  <= tx_ready_d;
            rx_valid_q  <= rx_valid_d;
            ack_error_q <= ack_error_d;
            rx_data_q   <= rx_data_d;
        end
    end

    assign scl_oe    = scl_oe_q;
    assign sda_oe    = sda_oe_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign tx_ready  = tx_ready_q;
    assign rx_valid  = rx_valid_q;
    assign ack_error = ack_error_q;
    assign rx_data   = rx_data_q;

endmodule

// File: tb/tb_i2c_master_burst.sv
// Bench for i2c_master_burst: bus-level slave model, protocol decoder and
// transaction-level expectations derived from the I2C framing rules.
`timescale 1ns/1ps
module tb_i2c_master_burst;
    localparam int D  = 4;
    localparam int LW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic start = 1'b0;
    logic rw = 1'b0;
    logic [6:0] addr = 7'h00;
    logic [LW-1:0] len = '0;
    logic [7:0] tx_data, rx_data;
    logic tx_ready, rx_valid, busy, done, ack_error;
    logic scl_i, sda_i, scl_oe, sda_oe;
    logic slv_sda_low = 1'b0;
    logic stretch = 1'b0;

    int total = 0;
    int bad = 0;

    logic [6:0] slv_addr = 7'h50;
    int nack_idx = -1;
    int stretch_bit = -1;
    logic [7:0] wr_arr [16];
    logic [7:0] rd_arr [16];

    int tx_idx = 0;
    int m_tx = 0, m_rx = 0, m_starts = 0, m_stops = 0;
    int bitn = 0, byte_no = 0, rd_i = 0, st_cnt = 0;
    logic prev_scl = 1'b1, prev_sda = 1'b1;
    logic active = 1'b0, is_read = 1'b0, addr_ok = 1'b0;
    logic rd_drive = 1'b0, st_done = 1'b0;
    logic [7:0] sh = 8'h00, rd_sh = 8'h00;
    logic [7:0] m_bytes [$];
    logic m_acks [$];
    logic [7:0] m_rxd [$];

    int o_cyc, o_to, o_tx, o_rx, o_starts, o_stops;
    logic o_err, o_busy, o_done_after;
    logic [7:0] o_bytes [$];
    logic o_acks [$];
    logic [7:0] o_rxd [$];

    int e_cyc, e_tx, e_rx;
    logic e_err;
    logic [7:0] e_bytes [$];
    logic e_acks [$];
    logic [7:0] e_rxd [$];

    always #5 clk = ~clk;

    assign scl_i = !(scl_oe || stretch);
    assign sda_i = !(sda_oe || slv_sda_low);
    assign tx_data = wr_arr[tx_idx[3:0]];

    i2c_master_burst #(.CLK_DIV(D), .LEN_W(LW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .addr(addr), .rw(rw),
        .len(len), .tx_data(tx_data), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy), .done(done),
        .ack_error(ack_error), .scl_i(scl_i), .sda_i(sda_i),
        .scl_oe(scl_oe), .sda_oe(sda_oe)
    );

    // Slave + bus decoder, sampled mid-cycle
    always @(negedge clk) begin
        logic sc, sd;
        sc = scl_i;
        sd = sda_i;
        if (!rst_n) begin
            active = 1'b0;
            slv_sda_low = 1'b0;
            stretch = 1'b0;
            prev_scl = 1'b1;
            prev_sda = 1'b1;
        end else begin
            if (start && !busy) tx_idx = 0;
            if (tx_ready) begin m_tx++; tx_idx++; end
            if (rx_valid) begin m_rx++; m_rxd.push_back(rx_data); end
            if (prev_scl && sc && prev_sda && !sd) begin
                m_starts++;
                active = 1'b1; bitn = 0; byte_no = 0; rd_i = 0;
                rd_drive = 1'b0; st_done = 1'b0; slv_sda_low = 1'b0;
            end else if (prev_scl && sc && !prev_sda && sd) begin
                m_stops++;
                active = 1'b0;
            end else if (active && !prev_scl && sc) begin
                if (bitn < 8) sh = {sh[6:0], sd};
                else m_acks.push_back(sd);
                bitn++;
                if (bitn == 8) begin
                    m_bytes.push_back(sh);
                    if (byte_no == 0) begin
                        is_read = sh[0];
                        addr_ok = (sh[7:1] == slv_addr);
                    end
                end
            end else if (active && prev_scl && !sc) begin
                if (bitn == 8) begin
                    rd_drive = 1'b0;
                    if (byte_no == 0) slv_sda_low = addr_ok;
                    else slv_sda_low = !is_read && ((byte_no - 1) != nack_idx);
                end else if (bitn == 9) begin
                    rd_drive = is_read && ((byte_no == 0) ? addr_ok : (m_acks[$] == 1'b0));
                    bitn = 0;
                    byte_no++;
                    slv_sda_low = 1'b0;
                    if (rd_drive) begin
                        rd_sh = rd_arr[rd_i[3:0]];
                        rd_i++;
                        slv_sda_low = !rd_sh[7];
                    end
                end else if (rd_drive) begin
                    rd_sh = rd_sh << 1;
                    slv_sda_low = !rd_sh[7];
                end
                if (byte_no == 1 && bitn == stretch_bit && !st_done) begin
                    stretch = 1'b1;
                    st_cnt = 0;
                    st_done = 1'b1;
                end
            end
            if (stretch && !scl_oe) begin
                st_cnt++;
                if (st_cnt == 51) stretch = 1'b0;
            end
            prev_scl = sc;
            prev_sda = sd;
        end
    end

    function automatic string fmtq(input logic [7:0] q[$]);
        string s = "";
        foreach (q[i]) s = {s, $sformatf("%02h ", q[i])};
        return s;
    endfunction

    function automatic string fmtb(input logic q[$]);
        string s = "";
        foreach (q[i]) s = {s, q[i] ? "1" : "0"};
        return s;
    endfunction

    task automatic kick(input logic [6:0] a, input logic r, input int l);
        @(posedge clk); #1;
        addr = a; rw = r; len = LW'(l); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic do_xfer(input logic [6:0] a, input logic r, input int l, input int poke);
        int s_tx, s_rx, s_b, s_a, s_r, s_st, s_sp;
        s_tx = m_tx; s_rx = m_rx; s_b = m_bytes.size(); s_a = m_acks.size();
        s_r = m_rxd.size(); s_st = m_starts; s_sp = m_stops;
        kick(a, r, l);
        o_cyc = 0;
        o_to = 0;
        while (!done) begin
            if (o_cyc == poke) begin addr = ~a; start = 1'b1; end
            else start = 1'b0;
            @(posedge clk); #1;
            o_cyc++;
            if (o_cyc > 20000) begin o_to = 1; break; end
        end
        start = 1'b0;
        o_err = ack_error;
        o_busy = busy;
        o_tx = m_tx - s_tx;
        o_rx = m_rx - s_rx;
        o_starts = m_starts - s_st;
        o_stops = m_stops - s_sp;
        o_bytes.delete(); o_acks.delete(); o_rxd.delete();
        for (int i = s_b; i < m_bytes.size(); i++) o_bytes.push_back(m_bytes[i]);
        for (int i = s_a; i < m_acks.size(); i++) o_acks.push_back(m_acks[i]);
        for (int i = s_r; i < m_rxd.size(); i++) o_rxd.push_back(m_rxd[i]);
        @(posedge clk); #1;
        o_done_after = done;
    endtask

    task automatic model(input logic [6:0] a, input logic r, input int l);
        int nb;
        logic aok;
        aok = (a == slv_addr);
        e_bytes.delete(); e_acks.delete(); e_rxd.delete();
        e_bytes.push_back({a, r});
        e_acks.push_back(!aok);
        nb = 0;
        if (aok) begin
            if (!r && nack_idx >= 0 && nack_idx < l) nb = nack_idx + 1;
            else nb = l;
        end
        for (int i = 0; i < nb; i++) begin
            if (r) begin
                e_bytes.push_back(rd_arr[i]);
                e_rxd.push_back(rd_arr[i]);
                e_acks.push_back(i == l - 1);
            end else begin
                e_bytes.push_back(wr_arr[i]);
                e_acks.push_back(i == nack_idx);
            end
        end
        e_err = !aok || (!r && nack_idx >= 0 && nack_idx < l);
        e_tx = r ? 0 : nb;
        e_rx = r ? nb : 0;
        e_cyc = (8 + 36 * (nb + 1)) * D + ((stretch_bit >= 0 && nb >= 1) ? 50 : 0);
    endtask

    task automatic test_reset();
        logic [14:0] v;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        v = {scl_oe, sda_oe, busy, done, tx_ready, rx_valid, ack_error, rx_data};
        total++;
        if (v !== 15'h0) begin bad++; $display("FAIL reset_outputs: got %h want 0000", v); end
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        v = {scl_oe, sda_oe, busy, done, tx_ready, rx_valid, ack_error, rx_data};
        total++;
        if (v !== 15'h0) begin bad++; $display("FAIL idle_outputs: got %h want 0000", v); end
    endtask

    task automatic test_write_burst();
        slv_addr = 7'h50; nack_idx = -1; stretch_bit = -1;
        wr_arr[0] = 8'hA5; wr_arr[1] = 8'h3C;
        do_xfer(7'h50, 1'b0, 2, -1);
        model(7'h50, 1'b0, 2);
        total++;
        if (fmtq(o_bytes) != fmtq(e_bytes)) begin bad++; $display("FAIL wr_bytes: got %s want %s", fmtq(o_bytes), fmtq(e_bytes)); end
        total++;
        if (fmtb(o_acks) != fmtb(e_acks)) begin bad++; $display("FAIL wr_acks: got %s want %s", fmtb(o_acks), fmtb(e_acks)); end
        total++;
        if (o_tx !== 2) begin bad++; $display("FAIL wr_tx_ready: got %0d want 2", o_tx); end
        total++;
        if (o_err !== 1'b0) begin bad++; $display("FAIL wr_ack_error: got %b want 0", o_err); end
        total++;
        if (o_to != 0 || o_cyc != 464) begin bad++; $display("FAIL wr_done_time: got %0d want 464", o_cyc); end
        total++;
        if ({o_busy, o_done_after} !== 2'b00) begin bad++; $display("FAIL wr_done_pulse: got %b want 00", {o_busy, o_done_after}); end
        total++;
        if (o_rx != 0 || o_starts != 1 || o_stops != 1) begin bad++; $display("FAIL wr_framing: got rx=%0d st=%0d sp=%0d want 0 1 1", o_rx, o_starts, o_stops); end
    endtask

    task automatic test_addr_nack();
        slv_addr = 7'h50; nack_idx = -1; stretch_bit = -1;
        do_xfer(7'h21, 1'b0, 3, -1);
        model(7'h21, 1'b0, 3);
        total++;
        if (o_err !== 1'b1) begin bad++; $display("FAIL an_ack_error: got %b want 1", o_err); end
        total++;
        if (o_tx != 0) begin bad++; $display("FAIL an_tx_ready: got %0d want 0", o_tx); end
        total++;
        if (o_to != 0 || o_cyc != 176) begin bad++; $display("FAIL an_done_time: got %0d want 176", o_cyc); end
        total++;
        if (fmtq(o_bytes) != fmtq(e_bytes) || fmtb(o_acks) != fmtb(e_acks) || o_stops != 1) begin
            bad++; $display("FAIL an_bus: got %s/%s sp=%0d want %s/%s sp=1", fmtq(o_bytes), fmtb(o_acks), o_stops, fmtq(e_bytes), fmtb(e_acks));
        end
    endtask

    task automatic test_read_burst();
        slv_addr = 7'h68; nack_idx = -1; stretch_bit = -1;
        rd_arr[0] = 8'h11; rd_arr[1] = 8'h22; rd_arr[2] = 8'h33;
        do_xfer(7'h68, 1'b1, 3, -1);
        model(7'h68, 1'b1, 3);
        total++;
        if (fmtq(o_bytes) != fmtq(e_bytes)) begin bad++; $display("FAIL rd_bytes: got %s want %s", fmtq(o_bytes), fmtq(e_bytes)); end
        total++;
        if (fmtb(o_acks) != "0001") begin bad++; $display("FAIL rd_acks: got %s want 0001", fmtb(o_acks)); end
        total++;
        if (fmtq(o_rxd) != fmtq(e_rxd) || o_rx != 3) begin bad++; $display("FAIL rd_rx: got %s n=%0d want %s n=3", fmtq(o_rxd), o_rx, fmtq(e_rxd)); end
        total++;
        if (o_tx != 0 || o_err !== 1'b0 || o_stops != 1) begin bad++; $display("FAIL rd_misc: got tx=%0d err=%b sp=%0d want 0 0 1", o_tx, o_err, o_stops); end
        total++;
        if (o_to != 0 || o_cyc != e_cyc) begin bad++; $display("FAIL rd_done_time: got %0d want %0d", o_cyc, e_cyc); end
    endtask

    task automatic test_clock_stretch();
        slv_addr = 7'h50; nack_idx = -1; stretch_bit = 4;
        wr_arr[0] = 8'hA5; wr_arr[1] = 8'h3C;
        do_xfer(7'h50, 1'b0, 2, -1);
        model(7'h50, 1'b0, 2);
        stretch_bit = -1;
        total++;
        if (o_to != 0 || o_cyc != 514) begin bad++; $display("FAIL cs_done_time: got %0d want 514", o_cyc); end
        total++;
        if (fmtq(o_bytes) != fmtq(e_bytes) || o_err !== 1'b0) begin bad++; $display("FAIL cs_data: got %s err=%b want %s err=0", fmtq(o_bytes), o_err, fmtq(e_bytes)); end
    endtask

    task automatic test_write_nack_busy();
        int st0;
        slv_addr = 7'h50; nack_idx = 1; stretch_bit = -1;
        for (int i = 0; i < 4; i++) wr_arr[i] = 8'(8'h81 + 8'(i * 17));
        do_xfer(7'h50, 1'b0, 4, 300);
        model(7'h50, 1'b0, 4);
        nack_idx = -1;
        total++;
        if (o_tx != 2 || o_err !== 1'b1) begin bad++; $display("FAIL wn_tx_err: got tx=%0d err=%b want 2 1", o_tx, o_err); end
        total++;
        if (fmtq(o_bytes) != fmtq(e_bytes) || fmtb(o_acks) != "001") begin bad++; $display("FAIL wn_bus: got %s/%s want %s/001", fmtq(o_bytes), fmtb(o_acks), fmtq(e_bytes)); end
        total++;
        if (o_to != 0 || o_cyc != e_cyc || o_stops != 1) begin bad++; $display("FAIL wn_done_time: got %0d sp=%0d want %0d sp=1", o_cyc, o_stops, e_cyc); end
        st0 = m_starts;
        repeat (10) @(posedge clk);
        #1;
        total++;
        if (busy !== 1'b0 || o_starts != 1 || m_starts != st0) begin bad++; $display("FAIL busy_start_ignored: got busy=%b starts=%0d want 0 1", busy, o_starts + m_starts - st0); end
    endtask

    task automatic test_reset_probe();
        logic [14:0] v;
        int n;
        slv_addr = 7'h68; nack_idx = -1; stretch_bit = -1;
        rd_arr[0] = 8'h5A; rd_arr[1] = 8'hC3; rd_arr[2] = 8'h0F;
        kick(7'h68, 1'b1, 3);
        repeat (210) @(posedge clk);
        #1;
        n = 0;
        while (!scl_oe && n < 20) begin @(posedge clk); #1; n++; end
        total++;
        if ({busy, scl_oe} !== 2'b11) begin bad++; $display("FAIL rp_pre_reset: got %b want 11", {busy, scl_oe}); end
        #2 rst_n = 1'b0;
        #1;
        v = {scl_oe, sda_oe, busy, done, tx_ready, rx_valid, ack_error, rx_data};
        total++;
        if (v !== 15'h0) begin bad++; $display("FAIL rp_async_reset: got %h want 0000", v); end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        slv_addr = 7'h50;
        do_xfer(7'h50, 1'b0, 0, -1);
        total++;
        if (o_to != 0 || o_cyc != 176 || o_err !== 1'b0 || o_tx != 0) begin
            bad++; $display("FAIL rp_probe: got cyc=%0d err=%b tx=%0d want 176 0 0", o_cyc, o_err, o_tx);
        end
    endtask

    task automatic test_random();
        logic [6:0] a;
        logic r;
        int l;
        for (int it = 0; it < 8; it++) begin
            slv_addr = 7'($urandom_range(8, 119));
            a = ($urandom % 4 != 0) ? slv_addr : 7'($urandom);
            r = 1'($urandom);
            l = $urandom_range(0, 5);
            if (l == 0) r = 1'b0;
            nack_idx = (!r && ($urandom % 3 == 0)) ? $urandom_range(0, 5) : -1;
            stretch_bit = -1;
            for (int i = 0; i < 16; i++) begin
                wr_arr[i] = 8'($urandom);
                rd_arr[i] = 8'($urandom);
            end
            do_xfer(a, r, l, -1);
            model(a, r, l);
            total++;
            if (fmtq(o_bytes) != fmtq(e_bytes)) begin bad++; $display("FAIL rnd%0d_bytes: got %s want %s", it, fmtq(o_bytes), fmtq(e_bytes)); end
            total++;
            if (fmtb(o_acks) != fmtb(e_acks)) begin bad++; $display("FAIL rnd%0d_acks: got %s want %s", it, fmtb(o_acks), fmtb(e_acks)); end
            total++;
            if (fmtq(o_rxd) != fmtq(e_rxd)) begin bad++; $display("FAIL rnd%0d_rx: got %s want %s", it, fmtq(o_rxd), fmtq(e_rxd)); end
            total++;
            if (o_tx != e_tx || o_rx != e_rx) begin bad++; $display("FAIL rnd%0d_pulses: got tx=%0d rx=%0d want %0d %0d", it, o_tx, o_rx, e_tx, e_rx); end
            total++;
            if (o_err !== e_err) begin bad++; $display("FAIL rnd%0d_err: got %b want %b", it, o_err, e_err); end
            total++;
            if (o_to != 0 || o_cyc != e_cyc || o_stops != 1) begin bad++; $display("FAIL rnd%0d_time: got %0d sp=%0d want %0d sp=1", it, o_cyc, o_stops, e_cyc); end
        end
        nack_idx = -1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin wr_arr[i] = 8'h00; rd_arr[i] = 8'h00; end
        test_reset();
        test_write_burst();
        test_addr_nack();
        test_read_burst();
        test_clock_stretch();
        test_write_nack_busy();
        test_reset_probe();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/i2c_master_burst.md
# i2c_master_burst

Parametrised multi-byte I2C master for single-master buses, the next generation of the team's single-byte I2C master. It runs addressed write or read bursts of 0 to 2^LEN_W-1 bytes, with a programmable SCL rate, open-drain pad controls and slave clock-stretching support. It sits between a register/CPU-side command port and the SCL/SDA pad cells. Byte data moves over per-byte handshakes.

## Interface
- CLK_DIV, 4: clk cycles per SCL quarter-period, ≥1; SCL period = 4*CLK_DIV cycles (stretch-free).
- LEN_W, 8: width of the byte-count field.

- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  command strobe, accepted only when busy=0.
- addr  in  7  7-bit slave address, sampled on accept.
- rw  in  1  0 = write, 1 = read, sampled on accept.
- len  in  LEN_W  byte count, sampled on accept; 0 = address-only probe.
- tx_data  in  8  write byte, sampled when tx_ready pulses.
- tx_ready  out  1  one-cycle pulse: tx_data consumed, present the next byte.
- rx_data  out  8  last received byte.
- rx_valid  out  1  one-cycle pulse: rx_data updated.
- busy  out  1  transaction in progress.
- done  out  1  one-cycle pulse at end of transaction.
- ack_error  out  1  a slave NACK occurred in the last transaction.
- scl_i, sda_i  in  1  pad input levels (already synchronised).
- scl_oe, sda_oe  out  1  1 = pull line low; 0 = release (pull-up high).

## Operation
- Reset values: scl_oe=0, sda_oe=0, busy=0, done=0, tx_ready=0, rx_valid=0, ack_error=0, rx_data=0x00.
- States: IDLE → START → ADDR (8 bits) → ADDR_ACK → {WR_BYTE → WR_ACK}* or {RD_BYTE → RD_ACK}* → STOP → IDLE.
- IDLE: both lines released.
  - start=1 latches addr, rw and len.
  - Clears ack_error.
  - Next cycle: busy=1, enter START.
- ADDR shifts {addr,rw} MSB first.
- ADDR_ACK: SDA released and sampled.
  - sda_i=1 → ack_error=1, go to STOP.
  - ACK with len=0 → STOP.
  - ACK otherwise → byte phase.
- WR_BYTE: tx_data is sampled and tx_ready pulses on the first cycle of bit 7.
  - WR_ACK NACK → ack_error=1, go to STOP; remaining bytes are abandoned.
  - WR_ACK ACK → next byte, or STOP after len bytes.
- RD_BYTE: SDA released, 8 bits sampled MSB first.
  - rx_data is updated and rx_valid pulses on the cycle the 8th bit is sampled.
  - RD_ACK: master drives ACK (sda_oe=1) for bytes 1..len-1 and NACK (released) for byte len.
- STOP → IDLE: done=1 and busy=0 on the same cycle. ack_error holds until the next accepted start.
- start while busy=1 is ignored and not queued.
- rst_n low mid-transaction: all outputs take their reset values immediately (asynchronous); the bus is released; the partial transfer is abandoned.

## Timing
- Each bit = quarters q0..q3, each CLK_DIV cycles.
  - q0, q1: scl_oe=1; SDA changes at the start of q0.
  - q2, q3: scl_oe=0.
  - SDA is sampled on the last cycle of q2.
- Clock stretching: the q2 counter holds while scl_oe=0 and scl_i=0; q2 counts only after scl_i reads 1.
- START (4 quarters): q0–q1 both released; q2–q3 sda_oe=1, SCL released.
- STOP (4 quarters):
  - q0–q1: scl_oe=1, sda_oe=1.
  - q2: SCL released, with stretch wait.
  - q3: SDA released.
- Stretch-free length, N data bytes: (8 + 36*(N+1)) * CLK_DIV cycles from the cycle after accept to done.
- tx_ready is never asserted for read transfers; rx_valid is never asserted for write transfers.

## Test plan
- **Write burst.** CLK_DIV=4, write, addr=0x50, len=2, data 0xA5 then 0x3C, slave ACKs all → SDA bytes 0xA0, 0xA5, 0x3C each followed by ACK; two tx_ready pulses; ack_error=0; done 464 cycles after accept.
- **Address NACK.** addr=0x21, no slave responds → ack_error=1, zero tx_ready pulses, STOP immediately after ADDR_ACK, done at (8+36)*4=176 cycles.
- **Read burst.** Read, addr=0x68, len=3, slave returns 0x11, 0x22, 0x33 → address byte 0xD1; rx_valid pulses with 0x11, 0x22, 0x33; master sends ACK, ACK, NACK; then STOP.
- **Clock stretch.** Slave holds SCL low 50 cycles during data bit 3 → that bit lengthens by exactly 50 cycles; data correct; done delayed by 50 cycles.
- **Write NACK mid-burst and start while busy.**
  - Write len=4, slave NACKs byte 2 → ack_error=1, exactly 2 tx_ready pulses, STOP follows.
  - start pulsed while busy → ignored.
- **Reset and probe.**
  - Assert rst_n low during read byte 1 → scl_oe, sda_oe, busy go to 0 asynchronously.
  - After release, len=0 probe to 0x50 with ACK → done at 176 cycles, ack_error=0.
